ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
Burst initiator for the team's 64x8 single-port RAM. It accepts a command carrying a start address, a length and a direction. It then moves a stream of bytes into RAM (write burst) or out of RAM (read burst) using valid/ready handshakes. It is the host-side master sitting between a byte-stream producer/consumer and the RAM's data_in/ram_address/write_enable/data_out pins.

Parameters:
ADDR_W, 6, RAM address width (depth 2**ADDR_W = 64)
DATA_W, 8, RAM word width
LEN_W, 7, burst length field width (lengths 0..64)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  LEN_W  number of words; 0 = empty burst
wr_valid  input  1  write-stream byte available
wr_ready  output  1  controller accepts write byte
wr_data  input  DATA_W  write-stream byte
rd_valid  output  1  read-stream byte available
rd_ready  input  1  consumer accepts read byte
rd_data  output  DATA_W  read-stream byte (registered)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at burst completion
ram_address  output  ADDR_W  to RAM ram_address
ram_data_in  output  DATA_W  to RAM data_in
ram_write_enable  output  1  to RAM write_enable
ram_data_out  input  DATA_W  from RAM data_out

Behaviour:
RAM timing contract:
- The RAM writes ram_data_in at the posedge when ram_write_enable=1.
- When ram_write_enable=0, the RAM registers ram_address at the posedge. ram_data_out is valid from that edge until the next address load.
- RAM contents are never reset by this block.

Internal registers: state, addr (ADDR_W), remaining (LEN_W), rd_data.
- ram_address = addr.
- ram_data_in = wr_data.
- All registers and outputs are cleared asynchronously when rst_n=0: state=IDLE, addr=0, remaining=0, rd_data=0, rd_valid=0, done=0, ram_write_enable=0.

States:
- IDLE
  - cmd_ready=1.
  - On cmd_valid: addr<=cmd_addr, remaining<=cmd_len.
  - If cmd_len==0, go to DONE.
  - Else go to WRITE if cmd_write, otherwise RD_ISSUE.
- WRITE
  - wr_ready=1; ram_write_enable = wr_valid (combinational).
  - On each wr_valid handshake: the word is written to addr, addr<=addr+1, remaining<=remaining-1.
  - When remaining==1 at the handshake, go to DONE. No stall cycles: one byte per clock when wr_valid is held high.
- RD_ISSUE
  - One cycle, ram_write_enable=0, ram_address=addr. The RAM latches addr at the edge. Go to RD_CAPT.
- RD_CAPT
  - One cycle: rd_data<=ram_data_out, rd_valid<=1, go to RD_OUT.
- RD_OUT
  - rd_valid=1, rd_data held stable until rd_ready.
  - On handshake: rd_valid<=0, addr<=addr+1, remaining<=remaining-1.
  - If remaining==1, go to DONE; else go to RD_ISSUE.
  - Read throughput is 1 word per 3 cycles with rd_ready tied high. First rd_valid is 2 cycles after command acceptance.
- DONE
  - done=1 for exactly one cycle, then IDLE.

Rules:
- Address wraps modulo 64 (63+1 -> 0). A 64-word burst from any start covers every location once.
- wr_valid while not in WRITE is ignored (wr_ready=0, no RAM write).
- rd_ready while rd_valid=0 has no effect.
- cmd_valid outside IDLE is ignored: it is not queued, and cmd_ready=0.
- cmd_len > 64 is out of contract: the controller takes remaining as given, and addresses wrap.
- Async reset mid-burst aborts immediately: no done pulse, any partial write stays in RAM, rd_valid drops.
- ram_write_enable is never high outside WRITE.

Test Plan:
1. Reset, then write cmd addr=5 len=4 with bytes 0x11,0x22,0x33,0x44 streamed back-to-back -> ram_write_enable high 4 consecutive cycles at addresses 5..8; done pulses once; busy falls the next cycle.
2. Read cmd addr=5 len=4, rd_ready=1 -> rd_data sequence 0x11,0x22,0x33,0x44; first rd_valid 2 cycles after acceptance; rd_valid spacing 3 cycles; one done pulse.
3. Write addr=62 len=4 with 0xA0..0xA3, then read back addr=62 len=4 -> writes land at 62,63,0,1; readback matches in order (wrap-around).
4. Read burst with rd_ready toggled 0/1 at random -> rd_data constant while rd_valid=1 and rd_ready=0; no byte lost or duplicated.
5. cmd_len=0 -> done pulses 1 cycle after acceptance; no RAM write; rd_valid never asserted.
6. Assert rst_n=0 after the 2nd byte of an 8-byte write -> all outputs 0 at once and no done; a later read shows bytes 1-2 written and bytes 3-8 untouched.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: valid/ready burst master that streams bytes into or out of a 64x8 single-port RAM
module ram_burst_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_CAPT, RD_OUT, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        rem_d   = cmd_len;
        state_d = (cmd_len == '0) ? DONE : cmd_write ? WRITE : RD_ISSUE;
      end
      WRITE: if (wr_valid) begin
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == LEN_W'(1)) ? DONE : WRITE;
      end
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        rd_data_d  = ram_data_out;
        rd_valid_d = 1'b1;
        state_d    = RD_OUT;
      end
      RD_OUT: if (rd_ready) begin
        rd_valid_d = 1'b0;
        addr_d     = addr_q + 1'b1;
        rem_d      = rem_q - 1'b1;
        state_d    = (rem_q == LEN_W'(1)) ? DONE : RD_ISSUE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  // RAM write strobe is combinational so a held wr_valid streams one byte per clock
  assign cmd_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign wr_ready         = (state_q == WRITE);
  assign ram_write_enable = wr_ready & wr_valid;
  assign ram_address      = addr_q;
  assign ram_data_in      = wr_data;
  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed bench with a RAM model, a transaction-level scoreboard and per-cycle checks
module tb_ram_burst_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr;
  logic [6:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, done;
  logic [5:0] ram_address;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_write_enable;
  logic       fill;

  ram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  logic [5:0] areg;
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 3);
    else if (ram_write_enable) mem[ram_address] <= ram_data_in;
    else areg <= ram_address;
  end
  assign ram_data_out = mem[areg];

  int total = 0, bad = 0, timeouts = 0;
  logic [7:0]  exp_mem [64];
  logic [13:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  wbuf [8];
  bit chk_spacing = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic exp_write(input logic [5:0] a, input logic [7:0] d);
    wq.push_back({a, d});
    exp_mem[a] = d;
  endtask

  task automatic exp_read(input logic [5:0] a);
    rq.push_back(exp_mem[a]);
  endtask

  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [6:0] l);
    int t = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) timeouts++;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic stream_wr(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      wr_valid = 1; wr_data = wbuf[i];
      while (!wr_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) timeouts++;
      @(posedge clk); #1;
    end
    wr_valid = 0;
  endtask

  task automatic wait_idle(input bit rnd);
    int t = 0;
    while (busy && t < 400) begin
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; t++;
    end
    if (t >= 400) timeouts++;
    rd_ready = 1;
  endtask

  // per-cycle scoreboard; cyc counts cycles since the cycle in which a command was accepted
  int cyc = 0, acc_len = 1, nrd = 0, last_rise = 0, we_run = 0, last_we_run = 0, done_cnt = 0;
  logic prv_rv = 0, prv_rr = 0, prv_done = 0;
  logic [7:0]  prv_rd = 0;
  logic [13:0] w;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_we", ram_write_enable, 0);
      wq.delete();
      prv_rv = 0; prv_rr = 0; prv_done = 0; we_run = 0;
    end else begin
      cyc++;
      if (cmd_valid && cmd_ready) begin cyc = 0; acc_len = int'(cmd_len); nrd = 0; end
      check("cmd_ready_vs_busy", cmd_ready, !busy);
      check("we_outside_write", ram_write_enable && !wr_ready, 0);
      if (ram_write_enable) begin
        if (wq.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = wq.pop_front();
          check("wr_addr", ram_address, w[13:8]);
          check("wr_data", ram_data_in, w[7:0]);
        end
        we_run++;
      end else if (we_run != 0) begin
        last_we_run = we_run;
        we_run = 0;
      end
      if (rd_valid && !prv_rv) begin
        check("rdv_expected", rq.size() != 0, 1);
        // rd_valid registers at the second edge after the accepting edge
        if (nrd == 0) check("rdv_edges_after_accept", cyc - 1, 2);
        else if (chk_spacing) check("rdv_spacing", cyc - last_rise, 3);
        last_rise = cyc;
        nrd++;
      end
      if (prv_rv && !prv_rr) begin
        check("rd_hold_valid", rd_valid, 1);
        check("rd_hold_data", rd_data, prv_rd);
      end
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_data", rd_data, rq.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("done_width", prv_done, 0);
        check("busy_during_done", busy, 1);
        if (acc_len == 0) check("len0_done_cycle", cyc, 1);
      end
      if (prv_done) check("busy_after_done", busy, 0);
      prv_rv = rd_valid; prv_rr = rd_ready; prv_rd = rd_data; prv_done = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; fill = 1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i * 7 + 3);
    repeat (2) @(posedge clk);
    #1 fill = 0;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rd_data", rd_data, 0);
    check("reset_ram_address", ram_address, 0);
    check("reset_wr_ready", wr_ready, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // 1: back-to-back write of four bytes at 5..8
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    exp_write(6'd5, 8'h11); exp_write(6'd6, 8'h22); exp_write(6'd7, 8'h33); exp_write(6'd8, 8'h44);
    send_cmd(1, 6'd5, 7'd4);
    stream_wr(4);
    wait_idle(0);
    check("t1_we_run", last_we_run, 4);

    // 2: read them back with rd_ready tied high
    rq.push_back(8'h11); rq.push_back(8'h22); rq.push_back(8'h33); rq.push_back(8'h44);
    chk_spacing = 1; rd_ready = 1;
    send_cmd(0, 6'd5, 7'd4);
    wait_idle(0);
    chk_spacing = 0;

    // 3: wrap-around write then read at 62
    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    exp_write(6'd62, 8'hA0); exp_write(6'd63, 8'hA1); exp_write(6'd0, 8'hA2); exp_write(6'd1, 8'hA3);
    send_cmd(1, 6'd62, 7'd4);
    stream_wr(4);
    wait_idle(0);
    check("t3_we_run", last_we_run, 4);
    rq.push_back(8'hA0); rq.push_back(8'hA1); rq.push_back(8'hA2); rq.push_back(8'hA3);
    chk_spacing = 1;
    send_cmd(0, 6'd62, 7'd4);
    wait_idle(0);
    chk_spacing = 0;

    // 4: read with random back-pressure
    for (int i = 0; i < 10; i++) exp_read(6'(i));
    rd_ready = 0;
    send_cmd(0, 6'd0, 7'd10);
    wait_idle(1);

    // 5: empty burst
    send_cmd(1, 6'd9, 7'd0);
    wait_idle(0);

    // 6: reset after the second byte of an eight-byte write
    for (int i = 0; i < 8; i++) wbuf[i] = 8'(8'hB0 + i);
    exp_write(6'd20, 8'hB0); exp_write(6'd21, 8'hB1);
    send_cmd(1, 6'd20, 7'd8);
    stream_wr(2);
    wr_valid = 1; wr_data = wbuf[2];
    #2 rst_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_we", ram_write_enable, 0);
    check("abort_done", done, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_ram_address", ram_address, 0);
    wr_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    rq.push_back(8'hB0); rq.push_back(8'hB1);
    for (int i = 2; i < 8; i++) exp_read(6'(20 + i));
    check("t6_untouched_model", exp_mem[22], 8'h9D);
    send_cmd(0, 6'd20, 7'd8);
    wait_idle(0);

    repeat (2) @(posedge clk); #1;
    check("done_count", done_cnt, 7);
    check("wq_left", wq.size(), 0);
    check("rq_left", rq.size(), 0);
    check("timeouts", timeouts, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
